// File: rtl/fwd_stall_ctrl.sv
// Result tracking through MEM/WB, operand forwarding to D and E, hazard stall
// generation and GRF write-port drive for the five-stage MIPS pipeline.
module fwd_stall_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_reg_write,
    input  logic [ADDR_W-1:0] ex_reg_addr,
    input  logic [DATA_W-1:0] ex_reg_data,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic [ADDR_W-1:0] d_rs_addr,
    input  logic [ADDR_W-1:0] d_rt_addr,
    input  logic [DATA_W-1:0] d_rs_grf,
    input  logic [DATA_W-1:0] d_rt_grf,
    input  logic              d_rs_use_d,
    input  logic              d_rt_use_d,
    input  logic              d_rs_use_e,
    input  logic              d_rt_use_e,
    input  logic [ADDR_W-1:0] e_rs_addr,
    input  logic [ADDR_W-1:0] e_rt_addr,
    input  logic [DATA_W-1:0] e_rs_val,
    input  logic [DATA_W-1:0] e_rt_val,
    output logic [DATA_W-1:0] d_rs_fwd,
    output logic [DATA_W-1:0] d_rt_fwd,
    output logic [DATA_W-1:0] e_rs_fwd,
    output logic [DATA_W-1:0] e_rt_fwd,
    output logic              stall,
    output logic              grf_we,
    output logic [ADDR_W-1:0] grf_waddr,
    output logic [DATA_W-1:0] grf_wdata
);

    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_load;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Register $0 never counts as a producer, so a zero source never matches.
    function automatic logic hit(input logic we, input logic [ADDR_W-1:0] waddr,
                                 input logic [ADDR_W-1:0] src);
        return we && (waddr == src) && (src != '0);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            m_we   <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
            m_load <= 1'b0;
            w_we   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            m_we   <= ex_reg_write;
            m_addr <= ex_reg_addr;
            m_data <= ex_reg_data;
            m_load <= ex_is_load;
            w_we   <= m_we;
            w_addr <= m_addr;
            w_data <= m_load ? dm_rdata : m_data;
        end
    end

    logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
    logic stall_rs, stall_rt;

    assign e_hit_rs = hit(ex_reg_write, ex_reg_addr, d_rs_addr);
    assign e_hit_rt = hit(ex_reg_write, ex_reg_addr, d_rt_addr);
    assign m_hit_rs = hit(m_we, m_addr, d_rs_addr);
    assign m_hit_rt = hit(m_we, m_addr, d_rt_addr);

    // A load in M only blocks a D-stage use; an E-stage use is served from W next cycle.
    assign stall_rs = (e_hit_rs && (d_rs_use_d || (ex_is_load && d_rs_use_e)))
                   || (m_hit_rs && m_load && d_rs_use_d);
    assign stall_rt = (e_hit_rt && (d_rt_use_d || (ex_is_load && d_rt_use_e)))
                   || (m_hit_rt && m_load && d_rt_use_d);
    assign stall    = stall_rs | stall_rt;

    always_comb begin
        d_rs_fwd = d_rs_grf;
        if (m_hit_rs && !m_load)            d_rs_fwd = m_data;
        else if (hit(w_we, w_addr, d_rs_addr)) d_rs_fwd = w_data;

        d_rt_fwd = d_rt_grf;
        if (m_hit_rt && !m_load)            d_rt_fwd = m_data;
        else if (hit(w_we, w_addr, d_rt_addr)) d_rt_fwd = w_data;

        e_rs_fwd = e_rs_val;
        if (hit(m_we, m_addr, e_rs_addr) && !m_load) e_rs_fwd = m_data;
        else if (hit(w_we, w_addr, e_rs_addr))       e_rs_fwd = w_data;

        e_rt_fwd = e_rt_val;
        if (hit(m_we, m_addr, e_rt_addr) && !m_load) e_rt_fwd = m_data;
        else if (hit(w_we, w_addr, e_rt_addr))       e_rt_fwd = w_data;
    end

    assign grf_we    = w_we && (w_addr != '0);
    assign grf_waddr = w_addr;
    assign grf_wdata = w_data;

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Scoreboard bench for fwd_stall_ctrl: directed cycles push expected values,
// a negedge monitor pops and compares them against the live outputs.
module tb_fwd_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_reg_write;
    logic [4:0]  ex_reg_addr;
    logic [31:0] ex_reg_data;
    logic        ex_is_load;
    logic [31:0] dm_rdata;
    logic [4:0]  d_rs_addr, d_rt_addr;
    logic [31:0] d_rs_grf, d_rt_grf;
    logic        d_rs_use_d, d_rt_use_d, d_rs_use_e, d_rt_use_e;
    logic [4:0]  e_rs_addr, e_rt_addr;
    logic [31:0] e_rs_val, e_rt_val;
    logic [31:0] d_rs_fwd, d_rt_fwd, e_rs_fwd, e_rt_fwd;
    logic        stall, grf_we;
    logic [4:0]  grf_waddr;
    logic [31:0] grf_wdata;

    fwd_stall_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .ex_reg_write(ex_reg_write), .ex_reg_addr(ex_reg_addr),
        .ex_reg_data(ex_reg_data), .ex_is_load(ex_is_load), .dm_rdata(dm_rdata),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
        .d_rs_grf(d_rs_grf), .d_rt_grf(d_rt_grf),
        .d_rs_use_d(d_rs_use_d), .d_rt_use_d(d_rt_use_d),
        .d_rs_use_e(d_rs_use_e), .d_rt_use_e(d_rt_use_e),
        .e_rs_addr(e_rs_addr), .e_rt_addr(e_rt_addr),
        .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
        .d_rs_fwd(d_rs_fwd), .d_rt_fwd(d_rt_fwd),
        .e_rs_fwd(e_rs_fwd), .e_rt_fwd(e_rt_fwd),
        .stall(stall), .grf_we(grf_we), .grf_waddr(grf_waddr), .grf_wdata(grf_wdata)
    );

    always #5 clk = ~clk;

    typedef enum int { S_STALL, S_DRS, S_DRT, S_ERS, S_ERT, S_GWE, S_GWA, S_GWD } sig_t;
    typedef struct { sig_t sig; logic [31:0] val; string name; } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    bit   stim_done = 1'b0;

    function automatic logic [31:0] actual(input sig_t s);
        case (s)
            S_STALL: return {31'd0, stall};
            S_DRS:   return d_rs_fwd;
            S_DRT:   return d_rt_fwd;
            S_ERS:   return e_rs_fwd;
            S_ERT:   return e_rt_fwd;
            S_GWE:   return {31'd0, grf_we};
            S_GWA:   return {27'd0, grf_waddr};
            default: return grf_wdata;
        endcase
    endfunction

    task automatic expect_val(input sig_t s, input logic [31:0] v, input string n);
        exp_t e;
        e.sig = s; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_reg_write = 1'b0; ex_reg_addr = '0; ex_reg_data = '0; ex_is_load = 1'b0;
        dm_rdata = '0;
        d_rs_addr = '0; d_rt_addr = '0; d_rs_grf = '0; d_rt_grf = '0;
        d_rs_use_d = 1'b0; d_rt_use_d = 1'b0; d_rs_use_e = 1'b0; d_rt_use_e = 1'b0;
        e_rs_addr = '0; e_rt_addr = '0; e_rs_val = '0; e_rt_val = '0;
    endtask

    // Monitor: every negedge, drain the expectations issued for this cycle.
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            // A loaded value in M must never be wanted by the E stage.
            assert (!(dut.m_we && dut.m_load && dut.m_addr != 5'd0 &&
                      (e_rs_addr == dut.m_addr || e_rt_addr == dut.m_addr)))
            else begin
                mismatched++;
                $display("FAIL load_in_m_used_by_e: m_addr=%0d e_rs=%0d e_rt=%0d",
                         dut.m_addr, e_rs_addr, e_rt_addr);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                a = actual(e.sig);
                compared++;
                if (a !== e.val) begin
                    mismatched++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, a, e.val, $time);
                end
            end
            if (stim_done) break;
        end
    end

    initial begin
        idle_inputs();
        // Reset held two cycles while EX presents a write to $3.
        reset = 1'b1; ex_reg_write = 1'b1; ex_reg_addr = 5'd3; ex_reg_data = 32'h99;
        cyc(); cyc();
        reset = 1'b0; idle_inputs();
        expect_val(S_GWE, 32'd0, "rst_grf_we");
        expect_val(S_GWA, 32'd0, "rst_grf_waddr");
        expect_val(S_GWD, 32'd0, "rst_grf_wdata");
        expect_val(S_STALL, 32'd0, "rst_stall");
        cyc(); cyc();

        // addu $3 = 0x11 followed by an E consumer of $3.
        ex_reg_write = 1'b1; ex_reg_addr = 5'd3; ex_reg_data = 32'h11;
        d_rs_addr = 5'd3; d_rs_use_e = 1'b1;
        expect_val(S_STALL, 32'd0, "alu_e_stall_a");
        cyc();
        idle_inputs();
        e_rs_addr = 5'd3; e_rs_val = 32'hBAD;
        expect_val(S_STALL, 32'd0, "alu_e_stall_b");
        expect_val(S_ERS, 32'h11, "alu_e_m_fwd");
        cyc();
        idle_inputs();
        d_rs_addr = 5'd3;
        expect_val(S_GWE, 32'd1, "alu_grf_we");
        expect_val(S_GWA, 32'd3, "alu_grf_waddr");
        expect_val(S_GWD, 32'h11, "alu_grf_wdata");
        expect_val(S_DRS, 32'h11, "alu_w_to_d");
        cyc();
        idle_inputs(); cyc(); cyc();

        // lw $5 with an E consumer on rt: one stall, then W->E.
        ex_reg_write = 1'b1; ex_reg_addr = 5'd5; ex_is_load = 1'b1; ex_reg_data = 32'h1234;
        d_rt_addr = 5'd5; d_rt_use_e = 1'b1;
        expect_val(S_STALL, 32'd1, "lw_e_stall_1");
        cyc();
        idle_inputs();
        d_rt_addr = 5'd5; d_rt_use_e = 1'b1; dm_rdata = 32'hDEADBEEF;
        expect_val(S_STALL, 32'd0, "lw_e_stall_2");
        cyc();
        idle_inputs();
        e_rt_addr = 5'd5; e_rt_val = 32'h0;
        expect_val(S_ERT, 32'hDEADBEEF, "lw_e_w_fwd");
        expect_val(S_GWD, 32'hDEADBEEF, "lw_grf_wdata");
        cyc();
        idle_inputs(); cyc(); cyc();

        // ori $4 = 0xFF then beq on rs: one stall, then M->D.
        ex_reg_write = 1'b1; ex_reg_addr = 5'd4; ex_reg_data = 32'hFF;
        d_rs_addr = 5'd4; d_rs_use_d = 1'b1;
        expect_val(S_STALL, 32'd1, "alu_d_stall_1");
        cyc();
        idle_inputs();
        d_rs_addr = 5'd4; d_rs_use_d = 1'b1;
        expect_val(S_STALL, 32'd0, "alu_d_stall_2");
        expect_val(S_DRS, 32'hFF, "alu_d_m_fwd");
        cyc();
        idle_inputs(); cyc(); cyc();

        // lw $4 then beq on rs: two stalls, then W->D.
        ex_reg_write = 1'b1; ex_reg_addr = 5'd4; ex_is_load = 1'b1;
        d_rs_addr = 5'd4; d_rs_use_d = 1'b1; d_rs_grf = 32'h4444;
        expect_val(S_STALL, 32'd1, "lw_d_stall_1");
        cyc();
        idle_inputs();
        d_rs_addr = 5'd4; d_rs_use_d = 1'b1; d_rs_grf = 32'h4444; dm_rdata = 32'hCAFEF00D;
        expect_val(S_STALL, 32'd1, "lw_d_stall_2");
        expect_val(S_DRS, 32'h4444, "lw_d_no_m_fwd");
        cyc();
        idle_inputs();
        d_rs_addr = 5'd4; d_rs_use_d = 1'b1; d_rs_grf = 32'h4444;
        expect_val(S_STALL, 32'd0, "lw_d_stall_3");
        expect_val(S_DRS, 32'hCAFEF00D, "lw_d_w_fwd");
        cyc();
        idle_inputs(); cyc(); cyc();

        // Writes to $0 are invisible.
        ex_reg_write = 1'b1; ex_reg_addr = 5'd0; ex_reg_data = 32'h55;
        d_rs_addr = 5'd0; d_rs_use_d = 1'b1;
        expect_val(S_STALL, 32'd0, "r0_stall");
        expect_val(S_DRS, 32'd0, "r0_d_fwd_a");
        cyc();
        idle_inputs();
        d_rs_use_d = 1'b1;
        expect_val(S_DRS, 32'd0, "r0_d_fwd_b");
        cyc();
        idle_inputs();
        expect_val(S_GWE, 32'd0, "r0_grf_we");
        cyc();
        idle_inputs(); cyc(); cyc();

        // M $7=1 over W $7=2, then W alone.
        ex_reg_write = 1'b1; ex_reg_addr = 5'd7; ex_reg_data = 32'h2;
        cyc();
        ex_reg_write = 1'b1; ex_reg_addr = 5'd7; ex_reg_data = 32'h1;
        cyc();
        idle_inputs();
        d_rs_addr = 5'd7; d_rt_addr = 5'd7; d_rs_grf = 32'h77; d_rt_grf = 32'h77;
        d_rs_use_e = 1'b1; e_rs_addr = 5'd7; e_rs_val = 32'h70;
        expect_val(S_DRS, 32'h1, "mw_d_rs");
        expect_val(S_DRT, 32'h1, "mw_d_rt");
        expect_val(S_ERS, 32'h1, "mw_e_rs");
        expect_val(S_STALL, 32'd0, "mw_stall");
        cyc();
        expect_val(S_DRS, 32'h1, "w_only_d_rs");
        expect_val(S_ERS, 32'h1, "w_only_e_rs");
        expect_val(S_GWD, 32'h1, "w_only_grf_wdata");
        cyc();
        idle_inputs(); cyc(); cyc();

        // Unused sources never stall; a D use of an E producer on rt does.
        ex_reg_write = 1'b1; ex_reg_addr = 5'd9; ex_is_load = 1'b1;
        d_rt_addr = 5'd9; d_rs_addr = 5'd9;
        expect_val(S_STALL, 32'd0, "nouse_stall");
        cyc();
        idle_inputs();
        ex_reg_write = 1'b1; ex_reg_addr = 5'd9;
        d_rt_addr = 5'd9; d_rt_use_d = 1'b1;
        expect_val(S_STALL, 32'd1, "rt_use_d_stall");
        cyc();
        idle_inputs();
        stim_done = 1'b1;
        cyc(); cyc();

        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fwd_stall_ctrl.md
# fwd_stall_ctrl

Register-result tracking, forwarding and stall control for the five-stage MIPS pipeline. It consumes the EX-stage write-back tuple (write enable, destination, data, load flag) produced by the ALU stage and carries it through internal MEM and WB registers. From those it returns forwarded operand values to the D and E stages, raises the D-stage stall on hazards it cannot forward, and drives the GRF write port.

## Interface
Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, data width

Ports (reset is synchronous, active-high, single clock):
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- ex_reg_write  in  1  EX instruction writes a register (bubble = 0)
- ex_reg_addr  in  ADDR_W  EX destination register
- ex_reg_data  in  DATA_W  EX result (ALU output / PC+8); ignored when ex_is_load
- ex_is_load  in  1  EX instruction is lw; its data comes from memory
- dm_rdata  in  DATA_W  data-memory read data for the instruction currently in MEM (combinational)
- d_rs_addr, d_rt_addr  in  ADDR_W  D-stage source registers
- d_rs_grf, d_rt_grf  in  DATA_W  GRF read values for the D sources
- d_rs_use_d, d_rt_use_d  in  1  source needed in D (beq, jr, jalr)
- d_rs_use_e, d_rt_use_e  in  1  source needed in E (ALU, address, store data)
- e_rs_addr, e_rt_addr  in  ADDR_W  E-stage source registers (from the D/E register)
- e_rs_val, e_rt_val  in  DATA_W  E-stage operand values latched in D/E
- d_rs_fwd, d_rt_fwd  out  DATA_W  forwarded D operands
- e_rs_fwd, e_rt_fwd  out  DATA_W  forwarded E operands (to the ALU)
- stall  out  1  freeze PC/F/D and insert a bubble into EX
- grf_we  out  1  GRF write enable
- grf_waddr  out  ADDR_W  GRF write address
- grf_wdata  out  DATA_W  GRF write data

## Operation
- Internal registers: M = {m_we, m_addr, m_data, m_load}; W = {w_we, w_addr, w_data}.
- The pipeline is never stalled past EX, so M and W advance every cycle unconditionally:
  - M ← {ex_reg_write, ex_reg_addr, ex_reg_data, ex_is_load}
  - W ← {m_we, m_addr, m_load ? dm_rdata : m_data}
- A tuple with address 0 is treated as non-writing for every purpose, including forwarding, stall and grf_we.
- Match(X, a) = x_we && x_addr == a && a != 0.
- Stall, per source s ∈ {rs, rt} of D:
  - stall_s = Match(E, s) && (use_d_s || (ex_is_load && use_e_s)) || Match(M, s) && m_load && use_d_s
  - stall = stall_rs | stall_rt.
- Sources with use_d = use_e = 0 never stall.
- D forwarding priority: M (only when !m_load) > W > d_*_grf. E results are never forwarded to D; that case stalls.
- E forwarding priority: M (only when !m_load) > W > e_*_val.
  - Match(M) with m_load for an E source is unreachable under the stall rule. The bench flags it as an assertion failure.
- GRF port: grf_we = w_we && w_addr != 0; grf_waddr = w_addr; grf_wdata = w_data.
- The W→D bypass covers the GRF write-then-read collision in the same cycle.

## Timing
- Reset: M and W are cleared (all we/addr/data/load = 0). Next cycle: grf_we = 0, grf_waddr = 0, grf_wdata = 0. Reset overrides any in-flight tuples; in-flight writes are lost.
- stall and all *_fwd outputs are combinational from the current inputs and M/W. No added latency.
- Producer-to-consumer gaps:
  - ALU result → E consumer in the next instruction: 0 stalls (M→E).
  - ALU result → D branch/jr consumer in the next instruction: 1 stall, then M→D.
  - lw → E consumer in the next instruction: 1 stall. On the next cycle the load is in M, and use_e alone does not stall. The value then reaches E via W→E.
  - lw → D consumer in the next instruction: 2 stalls, then W→D.
- Simultaneous M and W matches on the same register: the M (younger) value wins.

## Test plan
- Reset held 2 cycles with ex_reg_write=1, addr=3 → grf_we=0, grf_waddr=0, grf_wdata=0 on the first cycle after release.
- EX addu $3 = 0x11; next cycle E consumer rs=3 → stall=0 throughout; e_rs_fwd=0x11 (from M); two cycles after EX, grf_we=1, waddr=3, wdata=0x11.
- EX lw $5, D consumer rt=5 use_e=1 → stall=1 for exactly 1 cycle. dm_rdata=0xDEADBEEF while the load is in M. When the consumer is in E, e_rt_fwd=0xDEADBEEF.
- EX ori $4 = 0x00FF, D beq rs=4 use_d=1 → stall=1 for 1 cycle, then d_rs_fwd=0x00FF with stall=0. Repeat with lw $4 → stall=1 for 2 cycles, then d_rs_fwd = the loaded value.
- EX writes $0 (we=1, data=0x55), D reads rs=0 use_d=1, d_rs_grf=0 → stall=0, d_rs_fwd=0; two cycles later grf_we=0.
- M holds $7=0x1 (non-load) and W holds $7=0x2; D and E read $7 → d_rs_fwd=e_rs_fwd=0x1. Then clear M (ex_reg_write=0) → W holds 0x1, and both forwards return 0x1.
